// File: rtl/spart_driver.sv
// Bus master for the lab 1 SPART: programs the baud divisor from br_cfg, then
// echoes every received byte back through a small FIFO. All bus outputs are registered.
module spart_driver #(
  parameter int ECHO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_rx,
  output logic       ovf,
  output logic       cfg_done,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    CFG_LO = 3'd0,
    CFG_HI = 3'd1,
    IDLE   = 3'd2,
    RD_RX  = 3'd3,
    WR_TX  = 3'd4
  } state_t;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   divisor = 16'h028A;
      2'b01:   divisor = 16'h0145;
      2'b10:   divisor = 16'h00A2;
      default: divisor = 16'h0050;
    endcase
  endfunction

  state_t      state_q;
  logic [1:0]  cfg_q;
  logic        iocs_q, iorw_q, drive_q;
  logic [1:0]  ioaddr_q;
  logic [7:0]  dout_q, last_rx_q;
  logic        ovf_q, cfg_done_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [ECHO_DEPTH];

  logic [15:0] div_new, div_cur;
  logic        fifo_full, fifo_empty, push_d, pop_d;

  assign div_new    = divisor(br_cfg);
  assign div_cur    = divisor(cfg_q);
  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_d     = (state_q == RD_RX) && !fifo_full;
  assign pop_d      = (state_q == WR_TX);

  always_ff @(posedge clk) begin
    if (!rst && push_d) begin
      mem_q[wr_ptr_q[AW-1:0]] <= databus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Park in IDLE with cfg_done low so the first free cycle launches CFG_LO.
      state_q    <= IDLE;
      cfg_q      <= 2'b00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      drive_q    <= 1'b0;
      dout_q     <= 8'h00;
      last_rx_q  <= 8'h00;
      ovf_q      <= 1'b0;
      cfg_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      ioaddr_q <= 2'b00;
      drive_q  <= 1'b0;
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case (state_q)
        CFG_LO: begin
          state_q  <= CFG_HI;
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b11;
          drive_q  <= 1'b1;
          dout_q   <= div_cur[15:8];
        end
        CFG_HI: begin
          state_q    <= IDLE;
          cfg_done_q <= 1'b1;
        end
        RD_RX: begin
          state_q   <= IDLE;
          last_rx_q <= databus;
          if (fifo_full) ovf_q <= 1'b1;
        end
        WR_TX: begin
          state_q <= IDLE;
        end
        default: begin
          // IDLE; br_cfg and cfg_q agree from this edge on, so div_new is the captured divisor.
          if (!cfg_done_q || (br_cfg != cfg_q)) begin
            state_q    <= CFG_LO;
            cfg_done_q <= 1'b0;
            cfg_q      <= br_cfg;
            iocs_q     <= 1'b1;
            iorw_q     <= 1'b0;
            ioaddr_q   <= 2'b10;
            drive_q    <= 1'b1;
            dout_q     <= div_new[7:0];
          end else if (rda) begin
            state_q  <= RD_RX;
            iocs_q   <= 1'b1;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
          end else if (tbr && !fifo_empty) begin
            state_q  <= WR_TX;
            iocs_q   <= 1'b1;
            iorw_q   <= 1'b0;
            ioaddr_q <= 2'b00;
            drive_q  <= 1'b1;
            dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
          end
        end
      endcase
    end
  end

  assign iocs      = iocs_q;
  assign iorw      = iorw_q;
  assign ioaddr    = ioaddr_q;
  assign databus   = drive_q ? dout_q : 8'hzz;
  assign last_rx   = last_rx_q;
  assign ovf       = ovf_q;
  assign cfg_done  = cfg_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: divisor table after reset, directed echo/overflow/priority/
// reconfiguration/reset sequences, then a randomized echo run against a queue model.
module tb_spart_driver;

  localparam int DEPTH  = 4;
  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_BAD  = 3;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic       ovf, cfg_done;
  logic [2:0] dbg_state;
  logic [7:0] rx_byte;
  logic       spart_en;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;
  cfg_vec_t vecs[4];

  spart_driver #(.ECHO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .last_rx(last_rx), .ovf(ovf), .cfg_done(cfg_done), .dbg_state(dbg_state)
  );

  // SPART side: drives the RX byte only while the master reads the data register.
  assign spart_en = iocs && iorw && (ioaddr == 2'b00);
  assign databus  = spart_en ? rx_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_bus(input string nm, input logic e_cs, input logic e_rw,
                         input logic [1:0] e_addr);
    chk({nm, "_iocs"}, iocs, e_cs);
    chk({nm, "_iorw"}, iorw, e_rw);
    chk({nm, "_ioaddr"}, ioaddr, e_addr);
  endtask

  task automatic do_reset(input logic [1:0] cfg);
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; br_cfg = cfg;
    tick();
    tick();
    chk_bus("rst", 1'b0, 1'b1, 2'b00);
    chk("rst_last_rx", last_rx, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  // One read of byte b from an IDLE cycle; leaves the bench in the following IDLE cycle.
  task automatic rx_one(input string nm, input logic [7:0] b);
    rx_byte = b; rda = 1'b1;
    tick();
    chk_bus({nm, "_rd"}, 1'b1, 1'b1, 2'b00);
    rda = 1'b0;
    tick();
    chk_bus({nm, "_rd_idle"}, 1'b0, 1'b1, 2'b00);
    chk({nm, "_last_rx"}, last_rx, b);
  endtask

  task automatic tx_one(input string nm, input logic [7:0] b);
    tick();
    chk_bus({nm, "_wr"}, 1'b1, 1'b0, 2'b00);
    chk({nm, "_wr_data"}, databus, b);
    tick();
    chk_bus({nm, "_wr_idle"}, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic cfg_seq(input string nm, input logic [7:0] lo, input logic [7:0] hi);
    tick();
    chk_bus({nm, "_lo"}, 1'b1, 1'b0, 2'b10);
    chk({nm, "_lo_data"}, databus, lo);
    chk({nm, "_lo_done"}, cfg_done, 1'b0);
    tick();
    chk_bus({nm, "_hi"}, 1'b1, 1'b0, 2'b11);
    chk({nm, "_hi_data"}, databus, hi);
    tick();
    chk_bus({nm, "_idle"}, 1'b0, 1'b1, 2'b00);
    chk({nm, "_done"}, cfg_done, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_last;
    logic       exp_ovf;
    logic       prev_acc, prev_rda, prev_tbr;
    int         exp_kind, act_kind, pct;
    logic       drain;

    rst = 1'b1; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    vecs[0] = '{cfg: 2'b00, lo: 8'h8A, hi: 8'h02};
    vecs[1] = '{cfg: 2'b01, lo: 8'h45, hi: 8'h01};
    vecs[2] = '{cfg: 2'b11, lo: 8'h50, hi: 8'h00};
    vecs[3] = '{cfg: 2'b10, lo: 8'hA2, hi: 8'h00};
    @(negedge clk);

    // Divisor programming right after reset release: cycles 1, 2 write, cycle 3 done.
    for (int i = 0; i < 4; i++) begin
      do_reset(vecs[i].cfg);
      chk_bus("boot_lo", 1'b1, 1'b0, 2'b10);
      chk("boot_lo_data", databus, vecs[i].lo);
      chk("boot_lo_done", cfg_done, 1'b0);
      tick();
      chk_bus("boot_hi", 1'b1, 1'b0, 2'b11);
      chk("boot_hi_data", databus, vecs[i].hi);
      tick();
      chk_bus("boot_idle", 1'b0, 1'b1, 2'b00);
      chk("boot_done", cfg_done, 1'b1);
    end

    // Echo: IDLE (rda sampled), RD_RX, IDLE, WR_TX.
    tbr = 1'b1;
    rx_one("echo", 8'h41);
    tx_one("echo", 8'h41);

    // Overflow: five reads with tbr low, then four writes and no fifth.
    tbr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'h30 + 8'(i);
      rx_one("ovf", b);
      chk("ovf_flag", ovf, (i == 4));
    end
    tbr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'h30 + 8'(i);
      tx_one("drain", b);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_fifth_write", iocs, 1'b0);
    end

    // Reconfiguration from IDLE: 10 -> 00 -> 11, then echo resumes.
    br_cfg = 2'b00;
    cfg_seq("cfg00", 8'h8A, 8'h02);
    br_cfg = 2'b11;
    cfg_seq("cfg11", 8'h50, 8'h00);
    // Change during a read: finish read, one IDLE, then reconfigure before the pending write.
    rx_byte = 8'h5A; rda = 1'b1; tbr = 1'b1;
    tick();
    chk_bus("inflight_rd", 1'b1, 1'b1, 2'b00);
    rda = 1'b0; br_cfg = 2'b01;
    tick();
    chk_bus("inflight_idle", 1'b0, 1'b1, 2'b00);
    chk("inflight_last_rx", last_rx, 8'h5A);
    cfg_seq("cfg01", 8'h45, 8'h01);
    tx_one("resume", 8'h5A);

    // Read beats write when rda and tbr are both high.
    tbr = 1'b0;
    rx_one("prio_fill", 8'h55);
    tbr = 1'b1;
    rx_one("prio", 8'h66);
    tx_one("prio_first", 8'h55);
    tx_one("prio_second", 8'h66);
    tick();
    chk("prio_empty", iocs, 1'b0);

    // Reset in the middle of RD_RX discards FIFO and ovf.
    tbr = 1'b0;
    rx_one("rstmid_fill", 8'h77);
    chk("rstmid_ovf_before", ovf, 1'b1);
    rx_byte = 8'h88; rda = 1'b1;
    tick();
    chk_bus("rstmid_rd", 1'b1, 1'b1, 2'b00);
    rst = 1'b1; rda = 1'b0;
    tick();
    chk_bus("rstmid_rst", 1'b0, 1'b1, 2'b00);
    chk("rstmid_last_rx", last_rx, 8'h00);
    chk("rstmid_ovf", ovf, 1'b0);
    chk("rstmid_done", cfg_done, 1'b0);
    rst = 1'b0;
    tick();
    chk_bus("rstmid_lo", 1'b1, 1'b0, 2'b10);
    chk("rstmid_lo_data", databus, 8'h45);
    tick();
    chk_bus("rstmid_hi", 1'b1, 1'b0, 2'b11);
    chk("rstmid_hi_data", databus, 8'h01);
    tick();
    chk("rstmid_cfg_done", cfg_done, 1'b1);
    tbr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_fifo_empty", iocs, 1'b0);
    end

    // Random echo traffic checked against a FIFO queue model of the echo path.
    exp_q.delete();
    exp_last = 8'h00;
    exp_ovf  = 1'b0;
    prev_acc = 1'b0;
    prev_rda = rda;
    prev_tbr = tbr;
    drain    = 1'b0;
    for (int cyc = 0; cyc < 1840; cyc++) begin
      if (cyc >= 1800) drain = 1'b1;
      tick();
      chk("rnd_last_rx", last_rx, exp_last);
      chk("rnd_ovf", ovf, exp_ovf);
      if (prev_acc)                               exp_kind = K_NONE;
      else if (prev_rda)                          exp_kind = K_RD;
      else if (prev_tbr && (exp_q.size() > 0))    exp_kind = K_WR;
      else                                        exp_kind = K_NONE;
      if (!iocs)                                  act_kind = K_NONE;
      else if (iorw && (ioaddr == 2'b00))         act_kind = K_RD;
      else if (!iorw && (ioaddr == 2'b00))        act_kind = K_WR;
      else                                        act_kind = K_BAD;
      chk("rnd_access", act_kind, exp_kind);
      if (act_kind == K_RD) begin
        exp_last = rx_byte;
        if (exp_q.size() < DEPTH) exp_q.push_back(rx_byte);
        else                      exp_ovf = 1'b1;
        rda = 1'b0;
      end else if ((act_kind == K_WR) && (exp_q.size() > 0)) begin
        chk("rnd_tx_data", databus, exp_q.pop_front());
      end
      prev_acc = (act_kind != K_NONE);
      if (!drain && (act_kind != K_RD) && !rda && ($urandom_range(0, 2) == 0)) begin
        rda     = 1'b1;
        rx_byte = 8'($urandom);
      end
      case ((cyc / 250) % 3)
        0:       pct = 15;
        1:       pct = 60;
        default: pct = 90;
      endcase
      tbr      = drain ? 1'b1 : ($urandom_range(0, 99) < pct);
      prev_rda = rda;
      prev_tbr = tbr;
    end
    chk("rnd_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-master stage sitting directly upstream of the SPART on the lab 1 top level. It programs the SPART baud divisor from the board switches, then runs a character echo loop: every received byte is read out of the SPART, queued in a small echo FIFO, and written back to the transmitter when it reports buffer-ready. It also exports the last received byte for the HEX displays.

## Interface
- ECHO_DEPTH, 4: echo FIFO entries; power of two, at least 2.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- rda  input  1  SPART receive-data-available.
- tbr  input  1  SPART transmit-buffer-ready.
- iocs  output  1  SPART chip select; one cycle per access.
- iorw  output  1  1=read from SPART, 0=write to SPART.
- ioaddr  output  2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high.
- databus  inout  8  shared data bus; driven only during write cycles, else high-Z.
- last_rx  output  8  most recent byte read from RX buffer.
- ovf  output  1  sticky: a received byte was dropped because FIFO was full.
- cfg_done  output  1  high when the divisor for the current br_cfg is written.

## Operation
- Divisor constants, round(3125000/baud)-1: 4800 -> 0x028A, 9600 -> 0x0145, 19200 -> 0x00A2, 38400 -> 0x0050.
- States: CFG_LO, CFG_HI, IDLE, RD_RX, WR_TX.
- CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next state CFG_HI.
- CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state IDLE; cfg_done set.
- br_cfg is captured into cfg_q on entry to CFG_LO. The divisor is always taken from cfg_q, never from the live pins.
- IDLE evaluates in priority order:
  1. br_cfg != cfg_q -> CFG_LO, clear cfg_done.
  2. rda=1 -> RD_RX.
  3. tbr=1 and FIFO not empty -> WR_TX.
  4. Otherwise stay in IDLE.
- RD_RX: iocs=1, iorw=1, ioaddr=00, databus released. The databus value is sampled at the end of the cycle into last_rx and pushed into the FIFO.
  - If the FIFO is full, the byte is still read (clearing rda) and still written to last_rx, but is not pushed; ovf is set.
  - Next state IDLE.
- WR_TX: iocs=1, iorw=0, ioaddr=00, databus=FIFO head; FIFO pops at end of cycle; next state IDLE.
- Outside any write cycle, iocs=0, iorw=1, ioaddr=00, databus=Z.
- FIFO: pointers are log2(ECHO_DEPTH)+1 bits, so wrap-around is free and full/empty are distinguished by the MSB. Push and pop never occur in the same cycle.
- Reset mid-access abandons the access. The next cycle after release starts at CFG_LO; FIFO contents are discarded.

## Timing
- Reset values:
  - State: CFG_LO entered on the first cycle with rst=0.
  - Outputs: iocs=0, iorw=1, ioaddr=00, databus=Z, last_rx=0x00, ovf=0, cfg_done=0.
  - FIFO: empty.
- After rst falls:
  - Cycle 1: DB low write.
  - Cycle 2: DB high write.
  - cfg_done reads 1 from cycle 3.
- Every bus access is exactly one clk cycle, always followed by at least one IDLE cycle. The SPART's rda/tbr update is therefore visible before the next decision.
- Echo latency with the FIFO empty and tbr=1 is 4 cycles from rda sampled high to iocs asserted for WR_TX: IDLE, RD_RX, IDLE, WR_TX.
- A br_cfg change takes effect within one access: at most 1 cycle of in-flight access, then IDLE, then CFG_LO.
- rda and tbr both high in IDLE with the FIFO non-empty: the read wins; the write follows after the next IDLE.
- Sustained rda with tbr=0 fills the FIFO after ECHO_DEPTH reads; ovf is set on the (ECHO_DEPTH+1)th read.

## Test plan
- Reset with br_cfg=10 -> cycles 1-2 after release write 0xA2 to addr 10, then 0x00 to addr 11; cfg_done=1 in cycle 3; databus Z afterwards.
- rda pulse with SPART driving 0x41, tbr=1 -> last_rx=0x41; WR_TX places 0x41 on databus with ioaddr=00, iorw=0, exactly 4 cycles after rda was sampled.
- tbr held 0 while 5 bytes 0x30..0x34 arrive (ECHO_DEPTH=4) -> ovf=1 on the 5th read; last_rx=0x34. Raising tbr then transmits 0x30..0x33 in order and no fifth write occurs.
- br_cfg changed 00->11 while in IDLE -> cfg_done drops; the next two accesses write 0x50 then 0x00; echo resumes afterwards.
- rda and tbr both high with the FIFO holding 0x55 -> read occurs first, then 0x55 is written; the FIFO then holds only the new byte.
- rst asserted during an RD_RX cycle -> outputs return to reset values the next cycle; after release the sequence restarts at CFG_LO with the FIFO empty and ovf=0.
